// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone classic single-transfer initiator.
// It takes one command over a valid/ready channel and runs one cyc/stb
// read or write. It then returns the ack data over a valid/ready response
// channel. Every output comes straight from a flop.
// Optional feature: define WB_HOST_MASTER_TIMEOUT_EN to abort a transfer
// that has seen no ack for TIMEOUT_CYCLES bus cycles. An aborted transfer
// returns rsp_err=1. Without the macro the bus waits forever and rsp_err is 0.
module wb_host_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    output logic            busy,
    output logic [15:0]     txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              cmd_ready_n, rsp_valid_n, cyc_n, we_n, busy_n;
    logic [AW-1:0]     adr_n;
    logic [DW-1:0]     dat_n, rsp_dat_n;
    logic [DW/8-1:0]   sel_n;
    logic [15:0]       txn_count_n;

    // Classic Wishbone: strobe always follows cycle for single transfers
    assign wbm_stb_o = wbm_cyc_o;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            rsp_err_n;

    // Expiry fires on the edge that would bring the count to TIMEOUT_CYCLES
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Wait counter: held at zero outside BUS, so it starts at zero on entry
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            to_cnt <= '0;
        else if (state != BUS)
            to_cnt <= '0;
        else if (!wbm_ack_i)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign rsp_err = 1'b0;
`endif

    // Next-state and next-output decode; every register holds by default
    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready;
        rsp_valid_n = rsp_valid;
        rsp_dat_n   = rsp_dat;
        cyc_n       = wbm_cyc_o;
        we_n        = wbm_we_o;
        adr_n       = wbm_adr_o;
        dat_n       = wbm_dat_o;
        sel_n       = wbm_sel_o;
        txn_count_n = txn_count;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        rsp_err_n   = rsp_err;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_n        = cmd_we;
                    adr_n       = cmd_adr;
                    dat_n       = cmd_dat;
                    sel_n       = cmd_sel;
                    cyc_n       = 1'b1;
                    cmd_ready_n = 1'b0;
                    state_n     = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_n       = 1'b0;
                    rsp_dat_n   = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_valid_n = 1'b1;
                    txn_count_n = txn_count + 16'd1;
                    state_n     = RESP;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    rsp_err_n   = 1'b0;
                end else if (to_hit) begin
                    cyc_n       = 1'b0;
                    rsp_dat_n   = '0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    txn_count_n = txn_count + 16'd1;
                    state_n     = RESP;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                cyc_n       = 1'b0;
                rsp_valid_n = 1'b0;
                cmd_ready_n = 1'b1;
                state_n     = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset also kills an in-flight bus cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            busy      <= 1'b0;
            txn_count <= '0;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_dat   <= rsp_dat_n;
            wbm_cyc_o <= cyc_n;
            wbm_we_o  <= we_n;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
            wbm_sel_o <= sel_n;
            busy      <= busy_n;
            txn_count <= txn_count_n;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            rsp_err   <= rsp_err_n;
`endif
        end
    end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator: the host end of the bus that the user macro's `wbs_*` slave port responds to.
- Accepts one command at a time through a valid/ready command channel and runs exactly one cyc/stb transaction, read or write.
- Returns ack data, or a timeout error, through a valid/ready response channel.
- Sits in bring-up/test logic; commands come from LA registers or a UART bridge and drive the macro's slave port in simulation and FPGA emulation.

Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT_CYCLES, 255, cycles of stb without ack before abort (>=1; used only with macro)

Ports:
- wb_clk_i  in  1  clock, all logic rising-edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept command
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  AW  byte address
- cmd_dat  in  DW  write data
- cmd_sel  in  DW/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_dat  out  DW  read data (0 for writes)
- rsp_err  out  1  transaction timed out
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  AW  address
- wbm_dat_o  out  DW  write data
- wbm_sel_o  out  DW/8  byte select
- wbm_dat_i  in  DW  read data
- wbm_ack_i  in  1  slave acknowledge
- busy  out  1  state != IDLE
- txn_count  out  16  completed transactions (ack or timeout), wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - All outputs 0, except cmd_ready=1.
  - wbm_adr_o/dat_o/sel_o/we_o cleared to 0; txn_count=0; timeout counter=0.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: register we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, set cmd_ready=0, go to BUS.
  - Bus is active the cycle after acceptance (1-cycle latency).
- BUS:
  - cyc, stb, we, adr, dat and sel are held stable.
  - On an edge with wbm_ack_i=1: drop cyc/stb. For reads, rsp_dat<=wbm_dat_i; for writes, rsp_dat<=0. Set rsp_err<=0, rsp_valid<=1, increment txn_count, go to RESP.
  - Minimum turnaround is 2 cycles (ack in the first BUS cycle), so cyc is high for exactly 1 cycle.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until an edge with rsp_ready=1.
  - On that edge: rsp_valid<=0, cmd_ready<=1, go to IDLE.
  - A new command can be accepted no earlier than the cycle after the response is taken.
  - rsp_ready during IDLE/BUS is ignored.
- wbm_ack_i outside BUS is ignored: no state change, no count.
- wbm_we_o/adr_o/dat_o/sel_o keep their last values after cyc drops.
- Reset mid-BUS: cyc/stb drop immediately (async); the transaction is discarded and produces no response.
- Only one outstanding transaction. No pipelining, no burst (CTI/BTE not generated), no retry, no err_i.

Optional Feature:
- Macro WB_HOST_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter (width from TIMEOUT_CYCLES) clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: drop cyc/stb, rsp_dat<=0, rsp_err<=1, rsp_valid<=1, increment txn_count, go to RESP.
  - Ack on the same edge as expiry wins: normal completion, rsp_err=0.
- Undefined: no counter; BUS waits indefinitely; rsp_err is tied 0.

Test Plan:
- Reset check: hold wb_rst_i=1 with random inputs -> cmd_ready=1; cyc=stb=rsp_valid=rsp_err=busy=0; txn_count=0.
- Write, ack after 3 cycles: cmd we=1, adr=0x3000_0004, dat=0xCAFE_F00D, sel=0xF.
  - Next cycle: cyc=stb=we=1 with those values.
  - After ack: cyc=0, rsp_valid=1, rsp_dat=0, rsp_err=0, txn_count=1.
- Zero-wait read: cmd we=0, adr=0x3000_0000; slave acks in the first BUS cycle with dat_i=0x1234_5678.
  - cyc high exactly 1 cycle; rsp_dat=0x1234_5678.
  - rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and cmd_ready stays 0.
- Back-to-back: 4 commands with cmd_valid held continuously and rsp_ready=1.
  - Each accepted only after the previous response is taken.
  - txn_count=4; stray ack in IDLE does not change txn_count.
- Timeout (macro on, TIMEOUT_CYCLES=8), read with no ack:
  - cyc drops after 8 BUS cycles; rsp_err=1, rsp_dat=0.
  - Repeat with ack exactly on the expiry edge -> rsp_err=0.
- Async reset in BUS (cyc=1, before ack): cyc/stb go 0 without a clock edge; no rsp_valid; txn_count=0; cmd_ready=1 after release.
